// File: rtl/vdot_pkg.sv
// vdot_pkg
// Shared constants and helpers for the vdot_acc dot-product accumulator.
//   DEF_WIDTH / DEF_LANES : default operand width and lanes per beat
//   sat_add               : width-generic signed add with overflow detect
package vdot_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LANES = 4;

    // Adds two sign-extended operands and checks the sum against a w-bit
    // signed range. Bit 64 of the result is the overflow flag. With sat=1
    // the value is clamped to the w-bit range; with sat=0 the caller keeps
    // the low w bits, which is two's-complement wrap.
    function automatic logic [64:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w,
        input bit                 sat
    );
        logic signed [63:0] sum;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        logic               ovf;
        sum   = a + b;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        ovf   = (sum > max_v) || (sum < min_v);
        if (ovf && sat) begin
            sum = (sum > max_v) ? max_v : min_v;
        end
        return {ovf, sum};
    endfunction

endpackage

// File: rtl/vdot_reduce.sv
// vdot_reduce
// Pipeline stages 1-2: per-lane signed products, then their signed sum.
// A tag travels with each beat so side information stays aligned.
//   clock, reset : clock, synchronous active-low reset
//   i_en         : advance the pipeline (0 = hold everything)
//   i_valid/i_tag: incoming beat valid and side data
//   i_a, i_b     : packed signed lanes, lane i at [i*WIDTH +: WIDTH]
//   o_valid/o_tag: stage-2 valid and side data
//   o_sum        : stage-2 signed sum, full width
module vdot_reduce
    import vdot_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int TAG_W = 1,
    parameter int SUM_W = 2*WIDTH + $clog2(LANES)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_en,
    input  logic                    i_valid,
    input  logic [TAG_W-1:0]        i_tag,
    input  logic [LANES*WIDTH-1:0]  i_a,
    input  logic [LANES*WIDTH-1:0]  i_b,
    output logic                    o_valid,
    output logic [TAG_W-1:0]        o_tag,
    output logic signed [SUM_W-1:0] o_sum
);
    localparam int PW = 2*WIDTH;

    logic signed [PW-1:0]    r_prod [LANES];
    logic                    r_v1;
    logic [TAG_W-1:0]        r_tag1;
    logic                    r_v2;
    logic [TAG_W-1:0]        r_tag2;
    logic signed [SUM_W-1:0] r_sum;
    logic signed [SUM_W-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + SUM_W'(r_prod[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_v1   <= 1'b0;
            r_tag1 <= '0;
            r_v2   <= 1'b0;
            r_tag2 <= '0;
            r_sum  <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= '0;
            end
        end else if (i_en) begin
            r_v1   <= i_valid;
            r_tag1 <= i_tag;
            // Operands are widened first so the product is formed at full width.
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= PW'($signed(i_a[i*WIDTH +: WIDTH])) *
                             PW'($signed(i_b[i*WIDTH +: WIDTH]));
            end
            r_v2   <= r_v1;
            r_tag2 <= r_tag1;
            r_sum  <= w_sum;
        end
    end

    assign o_valid = r_v2;
    assign o_tag   = r_tag2;
    assign o_sum   = r_sum;

endmodule

// File: rtl/vdot_acc.sv
// vdot_acc
// Packetised signed dot-product accumulator, three pipeline stages:
// products, lane sum, then accumulate/output.
//   clock, reset          : clock, synchronous active-low reset
//   in_valid / in_ready   : beat handshake
//   in_a, in_b            : packed signed lanes
//   in_c                  : signed bias, used on a packet's first beat
//   in_first / in_last    : packet markers
//   out_valid / out_ready : result handshake
//   out_y / out_ovf       : packet result and sticky overflow flag
module vdot_acc
    import vdot_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LANES     = DEF_LANES,
    parameter int ACC_WIDTH = 2*WIDTH + $clog2(LANES) + 8,
    parameter int SATURATE  = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0]       in_c,
    input  logic                   in_first,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_y,
    output logic                   out_ovf
);
    localparam int SUM_W = 2*WIDTH + $clog2(LANES);
    localparam int TAG_W = WIDTH + 2;

    logic                        w_stall;
    logic                        w_v2;
    logic [TAG_W-1:0]            w_tag2;
    logic signed [SUM_W-1:0]     w_sum;
    logic                        w_first;
    logic                        w_last;
    logic signed [63:0]          w_base;
    logic [64:0]                 w_res;
    logic signed [ACC_WIDTH-1:0] w_acc_next;
    logic                        w_ovf_next;
    logic                        w_unused;

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        r_ovf;
    logic                        r_open;
    logic                        r_out_valid;
    logic [ACC_WIDTH-1:0]        r_y;
    logic                        r_out_ovf;

    // A held result blocks the whole pipeline; a result being consumed
    // this cycle frees the output register for the next one.
    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = reset && !w_stall;

    vdot_reduce #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .TAG_W (TAG_W),
        .SUM_W (SUM_W)
    ) u_reduce (
        .clock   (clock),
        .reset   (reset),
        .i_en    (!w_stall),
        .i_valid (in_valid && in_ready),
        .i_tag   ({in_c, in_first, in_last}),
        .i_a     (in_a),
        .i_b     (in_b),
        .o_valid (w_v2),
        .o_tag   (w_tag2),
        .o_sum   (w_sum)
    );

    // A beat with no packet open starts one, whatever its first marker says.
    assign w_first    = w_tag2[1] || !r_open;
    assign w_last     = w_tag2[0];
    assign w_base     = w_first ? 64'($signed(w_tag2[TAG_W-1:2])) : 64'(r_acc);
    assign w_res      = sat_add(w_base, 64'(w_sum), ACC_WIDTH, SATURATE != 0);
    assign w_acc_next = w_res[ACC_WIDTH-1:0];
    assign w_ovf_next = w_res[64] || (!w_first && r_ovf);
    assign w_unused   = ^w_res[63:ACC_WIDTH];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_open      <= 1'b0;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (!w_stall && w_v2) begin
                r_acc <= w_acc_next;
                r_ovf <= w_ovf_next;
                if (w_last) begin
                    r_open      <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_y         <= w_acc_next;
                    r_out_ovf   <= w_ovf_next;
                end else begin
                    r_open <= 1'b1;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_y     = r_y;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_vdot_acc.sv
module tb_vdot_acc;
    localparam int W  = 8;
    localparam int L  = 4;
    localparam int AW = 2*W + 2 + 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_first = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b1;
    logic [L*W-1:0] in_a = '0;
    logic [L*W-1:0] in_b = '0;
    logic [W-1:0]  in_c = '0;

    logic          in_ready, out_valid, out_ovf;
    logic [AW-1:0] out_y;
    logic          rdy_sat, ov_sat, ovf_sat, rdy_wrap, ov_wrap, ovf_wrap;
    logic [17:0]   y_sat, y_wrap;

    always #5 clock = ~clock;

    vdot_acc dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_ovf(out_ovf)
    );

    vdot_acc #(.WIDTH(8), .LANES(4), .ACC_WIDTH(18), .SATURATE(1)) dut_sat (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_sat),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_first(in_first), .in_last(in_last),
        .out_valid(ov_sat), .out_ready(out_ready), .out_y(y_sat), .out_ovf(ovf_sat)
    );

    vdot_acc #(.WIDTH(8), .LANES(4), .ACC_WIDTH(18), .SATURATE(0)) dut_wrap (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_wrap),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_first(in_first), .in_last(in_last),
        .out_valid(ov_wrap), .out_ready(out_ready), .out_y(y_wrap), .out_ovf(ovf_wrap)
    );

    typedef struct {
        logic [AW-1:0] y;
        logic          ovf;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     n_out = 0;
    longint m_acc = 0;
    bit     m_open = 0;
    bit     m_ovf = 0;

    function automatic logic [L*W-1:0] pack(input int l0, input int l1, input int l2, input int l3);
        return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    function automatic longint lane(input logic [L*W-1:0] v, input int i);
        logic [L*W-1:0] t;
        t = v;
        return longint'($signed(t[i*W +: W]));
    endfunction

    // Reference model of one accepted beat (AW-bit wrapping accumulator).
    task automatic model_beat(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                              input int c, input bit f, input bit l);
        longint sum, raw, t;
        bit     prev;
        exp_t   e;
        sum = 0;
        for (int i = 0; i < L; i++) sum += lane(a, i) * lane(b, i);
        if (f || !m_open) begin
            raw  = longint'(c) + sum;
            prev = 0;
        end else begin
            raw  = m_acc + sum;
            prev = m_ovf;
        end
        m_ovf = prev || (raw > ((64'sd1 <<< (AW-1)) - 1)) || (raw < -(64'sd1 <<< (AW-1)));
        t = raw & ((64'sd1 <<< AW) - 1);
        if (t >= (64'sd1 <<< (AW-1))) t -= (64'sd1 <<< AW);
        m_acc = t;
        if (l) begin
            e.y   = AW'(m_acc);
            e.ovf = m_ovf;
            sb.push_back(e);
            m_open = 0;
        end else begin
            m_open = 1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                             input int c, input bit f, input bit l);
        bit ok;
        in_a = a; in_b = b; in_c = 8'(c); in_first = f; in_last = l; in_valid = 1'b1;
        ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clock);
            ok = in_ready;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL beat_accept: in_ready stayed 0, required 1 within 200 cycles");
        end else begin
            model_beat(a, b, c, f, l);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_empty();
        for (int t = 0; t < 100 && sb.size() != 0; t++) idle(1);
        idle(2);
    endtask

    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            exp_t e;
            n_out++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got y=%0d, required no output", $signed(out_y));
            end else begin
                e = sb.pop_front();
                if (out_y !== e.y || out_ovf !== e.ovf) begin
                    n_fail++;
                    $display("FAIL result: got y=%0d ovf=%0b, required y=%0d ovf=%0b",
                             $signed(out_y), out_ovf, $signed(e.y), e.ovf);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        idle(3);
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b required 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0 || out_y !== '0 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b y=%0d ovf=%0b required 0 0 0", out_valid, out_y, out_ovf);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        m_open = 0;
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %0b required 1", in_ready); end
        @(posedge clock); #1;
    endtask

    task automatic test_single();
        logic [2:0] vseen;
        out_ready = 1'b1;
        send_beat(pack(-3, 28, 1, 0), pack(8, 1, 3, 0), 10, 1, 1);
        @(negedge clock); vseen[0] = out_valid;
        @(negedge clock); vseen[1] = out_valid;
        @(negedge clock); vseen[2] = out_valid;
        n_checks++;
        if (vseen !== 3'b100) begin n_fail++; $display("FAIL latency: got valid seq %b required 100", vseen); end
        n_checks++;
        if ($signed(out_y) !== 26'sd17 || out_ovf !== 1'b0) begin
            n_fail++; $display("FAIL single_beat: got y=%0d ovf=%0b required 17 0", $signed(out_y), out_ovf);
        end
        @(posedge clock); #1;
        wait_empty();
    endtask

    task automatic test_multi();
        int n0;
        n0 = n_out;
        for (int i = 0; i < 3; i++) send_beat(pack(1, 1, 1, 1), pack(2, 2, 2, 2), -5, i == 0, i == 2);
        wait_empty();
        n_checks++;
        if (n_out - n0 != 1 || sb.size() != 0) begin
            n_fail++; $display("FAIL multi_beat: got %0d outputs required 1 (expected 19)", n_out - n0);
        end
    endtask

    task automatic test_stall();
        int seen;
        out_ready = 1'b0;
        send_beat(pack(5, 0, 0, 0), pack(5, 0, 0, 0), 0, 1, 1);
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clock);
            seen = out_valid;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL stall_result: out_valid got 0 required 1"); end
        @(posedge clock); #1;
        in_a = pack(1, 2, 0, 0); in_b = pack(3, 4, 0, 0); in_c = 8'd1;
        in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || $signed(out_y) !== 26'sd25) begin
                n_fail++;
                $display("FAIL stall_hold: got ready=%0b valid=%0b y=%0d required 0 1 25",
                         in_ready, out_valid, $signed(out_y));
            end
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        send_beat(pack(1, 2, 0, 0), pack(3, 4, 0, 0), 1, 1, 1);
        wait_empty();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL stall_resume: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_overflow();
        int seen;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++)
            send_beat(pack(-128, -128, -128, -128), pack(-128, -128, -128, -128), 0, i == 0, i == 9);
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clock);
            seen = ov_sat;
        end
        n_checks++;
        if (!seen || y_sat !== 18'h1FFFF || ovf_sat !== 1'b1) begin
            n_fail++; $display("FAIL saturate: got valid=%0b y=%0d ovf=%0b required 1 131071 1", seen, $signed(y_sat), ovf_sat);
        end
        n_checks++;
        if (ov_wrap !== 1'b1 || y_wrap !== 18'h20000 || ovf_wrap !== 1'b1) begin
            n_fail++; $display("FAIL wrap: got valid=%0b y=%0d ovf=%0b required 1 -131072 1", ov_wrap, $signed(y_wrap), ovf_wrap);
        end
        @(posedge clock); #1;
        wait_empty();
    endtask

    task automatic test_reset_mid();
        int n0, bad;
        send_beat(pack(1, 1, 1, 1), pack(1, 1, 1, 1), 4, 1, 0);
        send_beat(pack(1, 1, 1, 1), pack(1, 1, 1, 1), 4, 0, 0);
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        m_open = 0;
        n0 = n_out;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (out_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL reset_mid_drop: got %0d valid cycles required 0", bad); end
        @(posedge clock); #1;
        send_beat(pack(2, 0, 0, 0), pack(3, 0, 0, 0), 0, 1, 1);
        wait_empty();
        n_checks++;
        if (n_out - n0 != 1) begin n_fail++; $display("FAIL reset_mid_next: got %0d outputs required 1", n_out - n0); end
    endtask

    task automatic test_restart();
        int n0;
        n0 = n_out;
        send_beat(pack(1, 1, 1, 1), pack(1, 1, 1, 1), 7, 1, 0);
        send_beat(pack(1, 1, 1, 1), pack(1, 1, 1, 1), 7, 0, 0);
        send_beat(pack(2, 2, 2, 2), pack(1, 1, 1, 1), 3, 1, 0);
        send_beat(pack(1, 0, 0, 0), pack(4, 0, 0, 0), 3, 0, 1);
        wait_empty();
        n_checks++;
        if (n_out - n0 != 1) begin n_fail++; $display("FAIL restart: got %0d outputs required 1", n_out - n0); end
    endtask

    task automatic test_implicit_first();
        int n0;
        n0 = n_out;
        send_beat(pack(3, 0, 0, 0), pack(3, 0, 0, 0), -2, 0, 1);
        wait_empty();
        n_checks++;
        if (n_out - n0 != 1) begin n_fail++; $display("FAIL implicit_first: got %0d outputs required 1", n_out - n0); end
    endtask

    task automatic test_back_to_back();
        int n0, len;
        n0 = n_out;
        for (int p = 0; p < 6; p++) begin
            len = int'($urandom_range(1, 3));
            for (int i = 0; i < len; i++) begin
                send_beat(pack(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                               int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128),
                          pack(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                               int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128),
                          int'($urandom_range(255)) - 128, i == 0, i == len - 1);
                if ($urandom_range(3) == 0) idle(1);
            end
        end
        wait_empty();
        n_checks++;
        if (n_out - n0 != 6 || sb.size() != 0) begin
            n_fail++; $display("FAIL back_to_back: got %0d outputs required 6", n_out - n0);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_restart();
        test_implicit_first();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vdot_acc.md
VDOT_ACC -- requirements
Module: vdot_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning signed operand width in bits.
REQ-002 SHALL have parameter LANES, default 4, meaning element pairs multiplied per beat (>=1).
REQ-003 SHALL have parameter ACC_WIDTH, default 2*WIDTH+$clog2(LANES)+8, meaning signed accumulator/result width.
REQ-004 SHALL have parameter SATURATE, default 0, meaning 1=saturating, 0=wrapping accumulation.
REQ-005 SHALL have port clock  input  1  clock; reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  beat valid.
REQ-007 SHALL have port in_ready  output  1  beat accepted when in_valid&&in_ready.
REQ-008 SHALL have port in_a, in_b  input  LANES*WIDTH  packed signed lanes, lane i at bits [i*WIDTH+:WIDTH].
REQ-009 SHALL have port in_c  input  WIDTH  signed bias, sampled on first beat only.
REQ-010 SHALL have port in_first, in_last  input  1  packet start/end markers.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  result consumed when out_valid&&out_ready.
REQ-013 SHALL have port out_y  output  ACC_WIDTH  signed packet result.
REQ-014 SHALL have port out_ovf  output  1  sticky overflow flag for the packet in out_y.

Function
REQ-015 Stage 1 SHALL register LANES signed products a_i*b_i at full 2*WIDTH width.
REQ-016 Stage 2 SHALL register the signed sum of stage-1 products, width 2*WIDTH+$clog2(LANES), no truncation.
REQ-017 Stage 3 SHALL accumulate: first beat -> acc = sext(in_c) + sum; other beats -> acc = acc + sum.
REQ-018 A beat with in_first=0 arriving while no packet is open SHALL be treated as a first beat.
REQ-019 in_first=1 mid-packet SHALL discard the open accumulation and restart; no result is emitted for the discarded packet.
REQ-020 in_first=in_last=1 SHALL form a single-beat packet.
REQ-021 On the last beat, out_y/out_ovf SHALL load the final acc and out_valid SHALL rise; latency = 3 cycles from acceptance of the last beat, absent stall.
REQ-022 Overflow beyond ACC_WIDTH SHALL set the packet's ovf; SATURATE=1 clamps to max/min signed, SATURATE=0 wraps two's complement.
REQ-023 Stall = out_valid && !out_ready && (a stage-3 result is pending); on stall all stages SHALL hold and in_ready SHALL be 0.
REQ-024 in_ready SHALL be 1 whenever not stalled; a result consumed and a new result produced in the same cycle SHALL not stall.
REQ-025 out_y/out_ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 Pipeline valid bits SHALL travel with data; bubbles (in_valid=0) SHALL not alter acc.

Reset
REQ-027 reset=0 at a rising clock edge SHALL clear all pipeline valid bits, acc, packet-open flag, out_valid, out_y and out_ovf to 0.
REQ-028 in_ready SHALL be 0 while reset=0 and 1 in the first cycle after release.
REQ-029 Reset mid-packet SHALL drop the packet; no partial result is emitted.

Structure
REQ-030 A shared package vdot_pkg SHALL hold the default WIDTH/LANES constants and the sat_add width-generic saturation helper.
REQ-031 One sub-module vdot_reduce (registered signed adder tree, parameter LANES, WIDTH) SHALL implement stages 1-2.

Verification
REQ-032 LANES=4: a=(-3,28,1,0), b=(8,1,3,0), c=10, first=last=1 -> out_y=17, out_ovf=0, 3 cycles after acceptance.
REQ-033 Three-beat packet a=(1,1,1,1), b=(2,2,2,2), c=-5 on beats 1-3 -> single result 19.
REQ-034 out_ready=0 for 5 cycles with result pending, in_valid=1 -> in_ready=0, out_y stable, no beat lost; resumes exactly.
REQ-035 WIDTH=8, ACC_WIDTH=18, 10 beats of a=b=(-128 x4) -> SATURATE=1 gives 131071, ovf=1; SATURATE=0 gives wrapped value, ovf=1.
REQ-036 reset=0 asserted after beat 2 of a 4-beat packet -> no output; next single-beat packet a=(2,0,0,0), b=(3,0,0,0), c=0 -> out_y=6.
REQ-037 in_first=1 mid-packet -> first packet discarded, only the restarted packet's result emitted.
